instruction_cache: RTL and testbench
====================================

Name: instruction_cache

Overview:
- Direct-mapped, read-only instruction cache between the CPU fetch stage (PC side) and the 128-bit block instruction memory.
- Serves 32-bit instruction words on a hit with no stall.
- On a miss, stalls the CPU via busywait, fetches the whole 16-byte block over the block-memory handshake, installs it, then serves the word.

Parameters:
- ADDR_W, 10, CPU byte-address width. Block address width is ADDR_W-4.
- INDEX_W, 3, set-index width. Sets = 2**INDEX_W = 8. Tag width = ADDR_W-4-INDEX_W = 3.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- read  in  1  CPU fetch request (level).
- address  in  ADDR_W  CPU byte address (PC). Bits [1:0] are ignored.
- readdata  out  32  selected instruction word.
- busywait  out  1  CPU stall.
- mem_read  out  1  block read request to instruction memory.
- mem_address  out  ADDR_W-4  block address = {tag,index}.
- mem_readdata  in  128  fetched block; byte 0 of the block is in [7:0].
- mem_busywait  in  1  memory busy. Memory raises it in the same cycle mem_read rises and drops it when mem_readdata is valid.

Behaviour:
- Reset (reset=0, asynchronous):
  - all valid bits cleared, FSM forced to IDLE.
  - mem_read=0, busywait=0, readdata=0.
  - Tag and data arrays are not cleared.
  - Reset during MEM_READ or UPDATE abandons the fill. The line is not installed and stays invalid.
- Address split: offset = address[3:0], word select = address[3:2], index = address[INDEX_W+3:4], tag = address[ADDR_W-1:INDEX_W+4].
- Hit = read && valid[index] && (tag_array[index]==tag), combinational.
- Word select: 0 -> block[31:0], 1 -> [63:32], 2 -> [95:64], 3 -> [127:96].
- readdata = selected word when hit in IDLE, else 0.
- FSM states:
  - IDLE:
    - busywait = read && !hit. mem_read=0.
    - On a miss at posedge: latch tag and index into miss registers, go to MEM_READ.
    - Hit or read=0: stay in IDLE.
  - MEM_READ:
    - mem_read=1, mem_address={latched tag, latched index}, busywait=1.
    - At posedge with mem_busywait=0: go to UPDATE.
    - Otherwise stay in MEM_READ; mem_read is held for any number of cycles.
  - UPDATE:
    - mem_read=0, busywait=1.
    - At posedge: data_array[idx] <= mem_readdata, tag_array[idx] <= latched tag, valid[idx] <= 1, go to IDLE.
- Miss penalty:
  - 1 cycle of miss detect, then N cycles of MEM_READ, then 1 cycle of UPDATE, then a hit in IDLE. busywait falls in that IDLE cycle.
- Conflicts: same index with a different tag evicts the old line. No write-back; the cache is read-only.
- The CPU holds address stable while busywait=1. The cache uses only the latched tag and index, so address changes during a fill do not corrupt the install.
- read=0 in IDLE: busywait=0, no state change.
- Highest block (address 0x3F0..0x3FF, mem_address 6'h3F) is handled like any other; there is no wrap issue.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- When defined, adds two output ports, hit_count[15:0] and miss_count[15:0].
  - hit_count increments on each posedge in IDLE with read && hit.
  - miss_count increments on each IDLE->MEM_READ transition.
  - Both saturate at 16'hFFFF and clear on reset.
- When undefined, the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
1. Cold miss: after reset release, read=1, address=0x000, block 0 word0=0x00010002.
   - busywait=1, mem_read=1, mem_address=0.
   - After mem_busywait falls, UPDATE, then readdata=0x00010002 and busywait=0.
2. Same-block hits: address 0x004, 0x008, 0x00C after test 1.
   - readdata=0x02000001, 0x0A000102, 0x0B000122 respectively.
   - busywait=0 and mem_read=0 throughout.
3. Conflict eviction: fetch 0x080 (index 0, tag 1), then 0x000.
   - Both miss; mem_address=6'h08 then 6'h00; each is correct after refill.
4. Long memory stall: hold mem_busywait=1 for 20 cycles in MEM_READ.
   - mem_read and busywait stay 1, no install.
   - Line installs exactly one cycle after mem_busywait drops.
5. Reset mid-fill: assert reset=0 while in MEM_READ.
   - Immediately mem_read=0 and busywait=0.
   - After release, a fetch of the same address misses again.
6. With ICACHE_STATS_EN, run tests 1 and 2.
   - miss_count=1, hit_count=4 (the post-fill hit on 0x000 plus the three hits in test 2).

Source files
------------

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: 32-bit word hits with no stall, 16-byte block refill on a miss.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module instruction_cache #(
    parameter int ADDR_W  = 10,
    parameter int INDEX_W = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                read,
    input  logic [ADDR_W-1:0]   address,
    output logic [31:0]         readdata,
    output logic                busywait,
    output logic                mem_read,
    output logic [ADDR_W-5:0]   mem_address,
    input  logic [127:0]        mem_readdata,
    input  logic                mem_busywait
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]         hit_count,
    output logic [15:0]         miss_count
`endif
);

    // state    | meaning
    // IDLE     | serve hits; a miss stalls the CPU and starts a refill
    // MEM_READ | block read outstanding, waiting for mem_busywait to drop
    // UPDATE   | install the returned block, tag and valid bit
    localparam int TAG_W = ADDR_W - 4 - INDEX_W;
    localparam int SETS  = 1 << INDEX_W;

    typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

    state_t               state_q, state_d;
    logic [SETS-1:0]      valid_q;
    logic [TAG_W-1:0]     tag_q  [SETS];
    logic [127:0]         data_q [SETS];
    logic [TAG_W-1:0]     miss_tag_q;
    logic [INDEX_W-1:0]   miss_idx_q;

    logic [INDEX_W-1:0]   idx;
    logic [TAG_W-1:0]     tag;
    logic [1:0]           wsel;
    logic                 hit;
    logic [127:0]         line;
    logic [31:0]          word;

    assign idx  = address[INDEX_W+3:4];
    assign tag  = address[ADDR_W-1:INDEX_W+4];
    assign wsel = address[3:2];
    assign hit  = read && valid_q[idx] && (tag_q[idx] == tag);
    assign line = data_q[idx];

    always_comb begin
        word = line[31:0];
        case (wsel)
            2'd0: word = line[31:0];
            2'd1: word = line[63:32];
            2'd2: word = line[95:64];
            2'd3: word = line[127:96];
            default: word = line[31:0];
        endcase
    end

    assign mem_address = {miss_tag_q, miss_idx_q};

    always_comb begin
        state_d  = state_q;
        busywait = 1'b0;
        mem_read = 1'b0;
        readdata = 32'd0;
        case (state_q)
            IDLE: begin
                // reset gating keeps the stall low while rst holds the FSM, even with read high
                busywait = reset && read && !hit;
                if (hit)
                    readdata = word;
                if (read && !hit)
                    state_d = MEM_READ;
            end
            MEM_READ: begin
                mem_read = 1'b1;
                busywait = 1'b1;
                if (!mem_busywait)
                    state_d = UPDATE;
            end
            UPDATE: begin
                busywait = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && read && !hit) begin
                miss_tag_q <= tag;
                miss_idx_q <= idx;
            end
            if (state_q == UPDATE)
                valid_q[miss_idx_q] <= 1'b1;
        end
    end

    // Tag and data storage are intentionally not reset; the valid bits guard them.
    always_ff @(posedge clock) begin
        if (state_q == UPDATE) begin
            data_q[miss_idx_q] <= mem_readdata;
            tag_q[miss_idx_q]  <= miss_tag_q;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [15:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (state_q == IDLE && hit && hit_cnt_q != 16'hFFFF)
                hit_cnt_q <= hit_cnt_q + 16'd1;
            if (state_q == IDLE && read && !hit && miss_cnt_q != 16'hFFFF)
                miss_cnt_q <= miss_cnt_q + 16'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Scoreboard bench for instruction_cache: stimulus pushes expected fetch results, a negedge monitor checks them.
// Counter checks are compiled in when ICACHE_STATS_EN is defined.
module tb_instruction_cache;

    logic         clock = 1'b0;
    logic         reset;
    logic         read;
    logic [9:0]   address;
    logic [31:0]  readdata;
    logic         busywait;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;
`ifdef ICACHE_STATS_EN
    logic [15:0]  hit_count, miss_count;
`endif

    instruction_cache #(.ADDR_W(10), .INDEX_W(3)) dut (
        .clock        (clock),
        .reset        (reset),
        .read         (read),
        .address      (address),
        .readdata     (readdata),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    always #5 clock = ~clock;

    // Block memory: busy from the first mem_read cycle for mem_lat cycles, data only when not busy.
    logic [127:0] mem_blocks [64];
    int           mem_lat = 1;
    int           lat_cnt = 0;
    bit           in_fill = 1'b0;

    assign mem_busywait = mem_read && (!in_fill || lat_cnt != 0);
    assign mem_readdata = mem_busywait ? {4{32'hDEADBEEF}} : mem_blocks[mem_address];

    always @(negedge clock or negedge reset) begin
        if (!reset) begin
            in_fill = 1'b0;
            lat_cnt = 0;
        end else if (mem_read) begin
            if (!in_fill) begin
                in_fill = 1'b1;
                lat_cnt = mem_lat - 1;
            end else if (lat_cnt != 0) begin
                lat_cnt = lat_cnt - 1;
            end
        end else begin
            in_fill = 1'b0;
        end
    end

    typedef struct {
        logic [31:0] data;
        bit          miss;
        logic [5:0]  maddr;
        int          stall;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: which tag each set currently holds.
    bit   mv [8];
    int   mt [8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    bit saw_mem  = 1'b0;
    int stall_cnt = 0;

    always @(negedge clock) begin
        if (!reset) begin
            q.delete();
            saw_mem   = 1'b0;
            stall_cnt = 0;
        end else begin
            if (mem_read && !saw_mem) begin
                saw_mem = 1'b1;
                if (q.size() == 0)
                    chk("fill_without_request", 1, 0);
                else begin
                    chk("fill_expected", 128'(mem_read), 128'(q[0].miss));
                    chk("mem_address", 128'(mem_address), 128'(q[0].maddr));
                end
            end
            if (read && busywait)
                stall_cnt++;
            else if (read) begin
                if (q.size() == 0)
                    chk("serve_without_request", 1, 0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("readdata", 128'(readdata), 128'(e.data));
                    chk("stall_cycles", 128'(stall_cnt), 128'(e.stall));
                    chk("miss_seen", 128'(saw_mem), 128'(e.miss));
                end
                saw_mem   = 1'b0;
                stall_cnt = 0;
            end
        end
    end

    task automatic issue(input logic [9:0] a, input int lat);
        exp_t         e;
        logic [127:0] blk;
        int           i, t, ws;
        blk = mem_blocks[a[9:4]];
        i   = int'(a[6:4]);
        t   = int'(a[9:7]);
        ws  = int'(a[3:2]);
        e.miss  = !(mv[i] && mt[i] == t);
        e.maddr = a[9:4];
        e.data  = blk[32*ws +: 32];
        e.stall = e.miss ? lat + 2 : 0;
        mv[i] = 1'b1;
        mt[i] = t;
        @(posedge clock);
        #1;
        mem_lat = lat;
        read    = 1'b1;
        address = a;
        q.push_back(e);
    endtask

    task automatic fetch(input logic [9:0] a, input int lat);
        bit done;
        issue(a, lat);
        done = 1'b0;
        for (int n = 0; n < lat + 20 && !done; n++) begin
            @(negedge clock);
            if (!busywait)
                done = 1'b1;
        end
        if (!done)
            chk("fetch_timeout", 0, 1);
    endtask

    task automatic idle_cycle();
        @(posedge clock);
        #1;
        read    = 1'b0;
        address = 10'($urandom);
    endtask

    initial begin
        logic [9:0] a;
        bit         seen;
        for (int b = 0; b < 64; b++)
            mem_blocks[b] = {$urandom, $urandom, $urandom, $urandom};
        mem_blocks[0] = {32'h0B000122, 32'h0A000102, 32'h02000001, 32'h00010002};
        for (int s = 0; s < 8; s++) begin
            mv[s] = 1'b0;
            mt[s] = 0;
        end

        reset   = 1'b0;
        read    = 1'b1;
        address = 10'h000;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_busywait", 128'(busywait), 0);
        chk("reset_mem_read", 128'(mem_read), 0);
        chk("reset_readdata", 128'(readdata), 0);
        read = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;

        // cold miss then same-block hits
        fetch(10'h000, 1);
        fetch(10'h004, 1);
        fetch(10'h008, 1);
        fetch(10'h00C, 1);
        idle_cycle();
`ifdef ICACHE_STATS_EN
        chk("miss_count", 128'(miss_count), 1);
        chk("hit_count", 128'(hit_count), 4);
`endif

        // conflict eviction on set 0
        fetch(10'h080, 2);
        fetch(10'h000, 3);
        fetch(10'h084, 1);

        // long memory stall
        fetch(10'h3F4, 20);
        fetch(10'h3FC, 1);
        idle_cycle();

        // reset in the middle of a fill
        issue(10'h250, 50);
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clock);
            if (mem_read)
                seen = 1'b1;
        end
        chk("reached_mem_read", 128'(seen), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("midfill_mem_read", 128'(mem_read), 0);
        chk("midfill_busywait", 128'(busywait), 0);
        chk("midfill_readdata", 128'(readdata), 0);
        for (int s = 0; s < 8; s++)
            mv[s] = 1'b0;
        read = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        fetch(10'h250, 2);
        fetch(10'h000, 1);

        // randomized traffic
        for (int k = 0; k < 200; k++) begin
            case ($urandom_range(0, 3))
                0: a = 10'($urandom);
                1: a = 10'($urandom_range(0, 255));
                2: a = {address[9:4], 4'($urandom)};
                default: a = {6'h3F, 4'($urandom)};
            endcase
            fetch(a, int'($urandom_range(1, 4)));
            if ($urandom_range(0, 3) == 0)
                idle_cycle();
        end
        idle_cycle();
        @(negedge clock);
        chk("queue_drained", 128'(q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
